lpf_channel_scheduler: RTL
==========================

# lpf_channel_scheduler

Time-multiplexes a single low-pass (x[n] + x[n-1]) filter datapath across `channels_p` independent audio sample streams. A round-robin arbiter picks one valid channel per cycle. It pairs that channel's new sample with the channel's own stored previous sample and emits the sum with a channel tag on a single ready/valid output. It sits between the per-channel sample sources and the shared downstream stage, and replaces one filter instance per channel.

## Interface
- `width_p`, default 8: sample width in bits; input, history and output all use this width.
- `channels_p`, default 2: number of input channels; legal range 2..16.
- `clk_i` input 1: the single clock.
- `reset_ni` input 1: asynchronous, active-low reset.
- `ch_data_i` input `channels_p*width_p`: per-channel samples; channel k occupies bits `[k*width_p +: width_p]`.
- `ch_valid_i` input `channels_p`: per-channel sample valid.
- `ch_ready_o` output `channels_p`: per-channel accept strobe. It is one-hot or zero.
- `flush_i` input 1: synchronous clear of all channel history registers.
- `data_o` output `width_p`: filtered sample.
- `channel_o` output `$clog2(channels_p)`: index of the channel that produced `data_o`.
- `valid_o` output 1: output holds a result.
- `ready_i` input 1: downstream accepts the result.

## Operation
- **State.** The block holds:
  - the history bank `prev[channels_p]`, `width_p` bits each;
  - the round-robin pointer `rr`, which names the highest-priority channel;
  - the output register `{data_o, channel_o, valid_o}`.
- **Slot free.** `slot_free = !valid_o || ready_i`.
- **Grant.** When `slot_free`, the grant `g` is the first channel with `ch_valid_i` set, searching `rr, rr+1, ...` modulo `channels_p`. `ch_ready_o[g]` is 1; all other bits are 0. If no channel is valid, or `slot_free` is 0, then `ch_ready_o` is 0.
- **Transfer.** A transfer occurs on channel g when `ch_valid_i[g] && ch_ready_o[g]`. On that clock edge:
  - `data_o <= ch_data[g] + prev[g]`, truncated to `width_p` bits (modulo 2^width_p wrap, no saturation);
  - `channel_o <= g`;
  - `valid_o <= 1`;
  - `prev[g] <= ch_data[g]`;
  - `rr <= (g+1) mod channels_p`.
- **Drain only.** If `slot_free` is 1, no channel is valid, and `ready_i` is 1, then `valid_o <= 0`. `data_o` and `channel_o` keep their last values.
- **Stall.** When `valid_o && !ready_i`:
  - `data_o`, `channel_o`, `valid_o`, `prev` and `rr` all hold;
  - no channel is granted.
- **Flush.** When `flush_i` is 1, every `prev` entry is cleared to 0 on that edge.
  - If a transfer happens in the same cycle, the emitted sum still uses the old `prev[g]`.
  - Flush wins over the history update, so `prev[g]` ends at 0.
  - Flush does not affect `rr` or the output register.
- **Idle channels.** A channel's history persists indefinitely while the channel is idle.
- **Stable-input requirement.** Upstream sources must keep `ch_data_i` stable while their valid is high and not yet accepted. The block does not register inputs before the grant.

## Timing
- **Reset values** while `reset_ni` is low (asynchronous assert; deassert is synchronised externally):
  - `valid_o` = 0, `data_o` = 0, `channel_o` = 0;
  - all `prev` = 0; `rr` = 0;
  - `ch_ready_o` is forced to 0.
- **Latency.** Exactly 1 cycle from the transfer edge to `valid_o`/`data_o` being visible.
- **Throughput.** One sample per cycle aggregate when `ready_i` is held high. With k channels continuously valid, each channel gets 1/k of the cycles. No channel waits more than `channels_p-1` grant opportunities.
- **Combinational paths.** `ch_ready_o` depends on `ready_i`, `valid_o`, `ch_valid_i` and `rr`. There is no combinational path from `ch_data_i` to any output.
- **Reset mid-operation.** Any result in the output register is dropped and all history is lost. The first post-reset transfer on each channel emits its raw sample.

## Test plan
- **Single channel** (`channels_p`=2). Ch0 sends 10, 20, 30 back-to-back; ch1 idle; `ready_i`=1. Expect `data_o` = 10, 30, 50 with `channel_o`=0, each one cycle after its transfer, and `ch_ready_o[1]` always 0.
- **Round-robin and wrap.** Both channels valid continuously; ch0 fixed at 5; ch1 sends 200, 100. Expect:
  - grants alternate 0, 1, 0, 1 starting from ch0;
  - outputs 5 (ch0), 200 (ch1), 10 (ch0), 44 (ch1, since 300 mod 256 = 44).
- **Backpressure.** With `valid_o`=1 holding 30 on ch0, hold `ready_i`=0 for 3 cycles while ch1 is valid. Expect:
  - `data_o`=30 and `channel_o`=0 stable;
  - `ch_ready_o`=0 throughout;
  - ch1 is granted in the cycle `ready_i` returns to 1.
- **Flush coincident with transfer.** `prev[0]`=40; ch0 sends 8 with `flush_i`=1 in the same cycle. Expect output 48. The next ch0 sample of 8 gives output 8.
- **Asynchronous reset mid-stream.** Drop `reset_ni` between clock edges while `valid_o`=1. Expect:
  - `valid_o`, `data_o` and `ch_ready_o` go to 0 immediately, without waiting for a clock edge;
  - after release, ch1 sending 7 yields 7, and the first grant starts the search from ch0.

Source files
------------

// File: rtl/lpf_channel_scheduler.sv
// lpf_channel_scheduler
//
// Shares one two-tap low-pass datapath (x[n] + x[n-1]) across channels_p
// sample streams. A round-robin arbiter grants one valid channel per cycle
// whenever the output slot is free. The granted sample is added to that
// channel's stored previous sample, and the sum is registered together with
// the channel index on a single ready/valid output.
//
// Ports:
//   clk_i       - clock
//   reset_ni    - asynchronous active-low reset
//   ch_data_i   - per-channel samples, channel k at [k*width_p +: width_p]
//   ch_valid_i  - per-channel sample valid
//   ch_ready_o  - per-channel accept strobe, one-hot or zero
//   flush_i     - synchronous clear of every channel's history
//   data_o      - filtered sample (modulo 2^width_p)
//   channel_o   - channel that produced data_o
//   valid_o     - output register holds a result
//   ready_i     - downstream accepts the result
module lpf_channel_scheduler #(
   parameter int width_p    = 8,
   parameter int channels_p = 2
) (
   input  logic                          clk_i,
   input  logic                          reset_ni,
   input  logic [channels_p*width_p-1:0] ch_data_i,
   input  logic [channels_p-1:0]         ch_valid_i,
   output logic [channels_p-1:0]         ch_ready_o,
   input  logic                          flush_i,
   output logic [width_p-1:0]            data_o,
   output logic [$clog2(channels_p)-1:0] channel_o,
   output logic                          valid_o,
   input  logic                          ready_i
);

   localparam int idx_w_lp = $clog2(channels_p);
   localparam logic [channels_p-1:0] one_lp = {{(channels_p-1){1'b0}}, 1'b1};
   localparam logic [idx_w_lp-1:0] last_idx_lp = idx_w_lp'(channels_p - 1);

   logic [width_p-1:0]    prev_r [channels_p];
   logic [idx_w_lp-1:0]   rr_r;
   logic [width_p-1:0]    data_r;
   logic [idx_w_lp-1:0]   channel_r;
   logic                  valid_r;

   logic [width_p-1:0]    ch_data_s [channels_p];
   logic                  slot_free_s;
   logic                  grant_found_s;
   logic [idx_w_lp-1:0]   grant_idx_s;
   logic [width_p-1:0]    grant_data_s;
   logic [width_p-1:0]    grant_sum_s;
   logic [idx_w_lp-1:0]   next_rr_s;
   logic [channels_p-1:0] grant_vec_s;

   // Unpack the flat sample bus into one entry per channel.
   for (genvar k = 0; k < channels_p; k++) begin : g_unpack
      assign ch_data_s[k] = ch_data_i[k*width_p +: width_p];
   end

   assign slot_free_s = !valid_r || ready_i;

   // Round-robin search starting at rr_r; the first valid channel wins.
   always_comb begin : grant_search
      int                  cand_v;
      logic [idx_w_lp-1:0] cand_idx_v;
      grant_found_s = 1'b0;
      grant_idx_s   = '0;
      cand_v        = 0;
      cand_idx_v    = '0;
      for (int off = 0; off < channels_p; off++) begin
         cand_v = int'(rr_r) + off;
         if (cand_v >= channels_p) begin
            cand_v = cand_v - channels_p;
         end else begin
            cand_v = cand_v;
         end
         cand_idx_v = cand_v[idx_w_lp-1:0];
         if (slot_free_s && !grant_found_s && ch_valid_i[cand_idx_v]) begin
            grant_found_s = 1'b1;
            grant_idx_s   = cand_idx_v;
         end else begin
            grant_found_s = grant_found_s;
         end
      end
   end

   // Datapath for the granted channel: sample, wrapped sum and next pointer.
   always_comb begin
      grant_data_s = ch_data_s[grant_idx_s];
      grant_sum_s  = grant_data_s + prev_r[grant_idx_s];
      if (grant_idx_s == last_idx_lp) begin
         next_rr_s = '0;
      end else begin
         next_rr_s = grant_idx_s + 1'b1;
      end
      if (grant_found_s) begin
         grant_vec_s = one_lp << grant_idx_s;
      end else begin
         grant_vec_s = '0;
      end
   end

   // Accept strobes are held low for the whole time reset is asserted,
   // not just after the first edge.
   assign ch_ready_o = reset_ni ? grant_vec_s : '0;

   // Output register and round-robin pointer.
   always_ff @(posedge clk_i or negedge reset_ni) begin
      if (!reset_ni) begin
         data_r    <= '0;
         channel_r <= '0;
         valid_r   <= 1'b0;
         rr_r      <= '0;
      end else begin
         if (grant_found_s) begin
            data_r    <= grant_sum_s;
            channel_r <= grant_idx_s;
            valid_r   <= 1'b1;
            rr_r      <= next_rr_s;
         end else if (ready_i) begin
            // Slot drained with nothing new to load; data/channel keep value.
            valid_r <= 1'b0;
         end else begin
            valid_r <= valid_r;
         end
      end
   end

   // History bank; a flush overrides the update of the granted channel.
   always_ff @(posedge clk_i or negedge reset_ni) begin
      if (!reset_ni) begin
         for (int k = 0; k < channels_p; k++) begin
            prev_r[k] <= '0;
         end
      end else begin
         for (int k = 0; k < channels_p; k++) begin
            if (flush_i) begin
               prev_r[k] <= '0;
            end else if (grant_found_s && (grant_idx_s == idx_w_lp'(k))) begin
               prev_r[k] <= grant_data_s;
            end else begin
               prev_r[k] <= prev_r[k];
            end
         end
      end
   end

   assign data_o    = data_r;
   assign channel_o = channel_r;
   assign valid_o   = valid_r;

endmodule
